// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive path.
package usb_rx_pkg;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  // Serial LFSR form: bits enter in wire order (LSB of each byte first).
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_PID  = 2'b01,
    ERR_CRC  = 2'b10,
    ERR_LEN  = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    IDLE,
    PID,
    HSHK,
    DATA,
    DONE,
    ERR
  } state_e;

  // A PID is self-checking: the upper nibble is the complement of the lower.
  function automatic logic pid_check_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial CRC16 LFSR shared by the receive and transmit paths.
module usb_crc16_serial
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic        d,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ d;

  // One LFSR step per enabled bit; init has priority over shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC16_INIT;
    end else if (init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/usb_rx_pkt_parser.sv
// Receive packet parser: PID capture/validation, payload collection with
// CRC16 residual check, and a held result for the protocol FSM.
module usb_rx_pkt_parser
  import usb_rx_pkg::*;
#(
  parameter  int MAX_BYTES = 8,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   abort,
  input  logic                   s_in,
  input  logic                   s_valid,
  input  logic                   sop,
  input  logic                   eop,
  input  logic                   pkt_ack,
  output logic                   pkt_valid,
  output logic                   pkt_is_data,
  output logic [7:0]             pkt_pid,
  output logic [8*MAX_BYTES-1:0] pkt_data,
  output logic [LEN_W-1:0]       pkt_len,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic                   busy
);

  // Payload plus the two trailing CRC bytes.
  localparam int BUF_BYTES = MAX_BYTES + 2;
  localparam int CNT_W     = $clog2(BUF_BYTES + 1);

  state_e           state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       shreg;
  logic [7:0]       buf_q [BUF_BYTES];
  logic [15:0]      crc;
  logic             capturing;
  logic             crc_init;
  logic             crc_en;
  logic [7:0]       pid_next;
  logic [7:0]       byte_next;

  // A sop restarts capture from any state except while a result is held.
  assign capturing = (state == IDLE) || (state == PID) ||
                     (state == HSHK) || (state == DATA);
  assign crc_init  = sop && capturing;
  assign crc_en    = (state == DATA) && s_valid && !sop && !abort;
  assign pid_next  = {s_in, pkt_pid[7:1]};
  assign byte_next = {s_in, shreg[7:1]};
  assign busy      = (state != IDLE);

  usb_crc16_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .d     (s_in),
    .crc   (crc)
  );

  // Packet FSM: priority is abort, then sop restart, then bit/eop handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shreg       <= '0;
      pkt_pid     <= '0;
      pkt_len     <= '0;
      pkt_valid   <= 1'b0;
      pkt_is_data <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
      // NOTE: the payload buffer is reset too, so pkt_data reads 0 out of reset.
      for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
    end else if (abort) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state     <= IDLE;
      pkt_valid <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (sop && capturing) begin
      // A real bit may accompany sop; it is the first PID bit.
      state       <= PID;
      bit_cnt     <= s_valid ? 3'd1 : 3'd0;
      pkt_pid     <= s_valid ? {s_in, 7'b0} : 8'h00;
      byte_cnt    <= '0;
      shreg       <= '0;
      pkt_len     <= '0;
      pkt_is_data <= 1'b0;
      for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
    end else begin
      case (state)
        IDLE: ;
        PID: begin
          if (eop) begin
            state     <= ERR;
            err_valid <= 1'b1;
            err_code  <= ERR_LEN;
          end else if (s_valid) begin
            pkt_pid <= pid_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (!pid_check_ok(pid_next)) begin
                state     <= ERR;
                err_valid <= 1'b1;
                err_code  <= ERR_PID;
              end else if (pid_next == PID_ACK || pid_next == PID_NAK) begin
                state <= HSHK;
              end else if (pid_next == PID_DATA0 || pid_next == PID_DATA1) begin
                state <= DATA;
              end else begin
                state     <= ERR;
                err_valid <= 1'b1;
                err_code  <= ERR_PID;
              end
            end
          end
        end
        HSHK: begin
          if (s_valid) begin
            state     <= ERR;
            err_valid <= 1'b1;
            err_code  <= ERR_LEN;
          end else if (eop) begin
            state       <= DONE;
            pkt_valid   <= 1'b1;
            pkt_is_data <= 1'b0;
          end
        end
        DATA: begin
          if (eop) begin
            if (bit_cnt != 3'd0 || byte_cnt < CNT_W'(2)) begin
              state     <= ERR;
              err_valid <= 1'b1;
              err_code  <= ERR_LEN;
            end else if (crc != CRC16_RESIDUAL) begin
              state     <= ERR;
              err_valid <= 1'b1;
              err_code  <= ERR_CRC;
            end else begin
              state       <= DONE;
              pkt_valid   <= 1'b1;
              pkt_is_data <= 1'b1;
              pkt_len     <= LEN_W'(byte_cnt - CNT_W'(2));
            end
          end else if (s_valid) begin
            shreg   <= byte_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == CNT_W'(BUF_BYTES)) begin
                state     <= ERR;
                err_valid <= 1'b1;
                err_code  <= ERR_LEN;
              end else begin
                buf_q[byte_cnt] <= byte_next;
                byte_cnt        <= byte_cnt + CNT_W'(1);
              end
            end
          end
        end
        DONE, ERR: begin
          if (pkt_ack) begin
            state     <= IDLE;
            pkt_valid <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Expose only the first pkt_len payload bytes; CRC bytes never appear.
  always_comb begin
    // NOTE: default the whole bus first so no bit is left unassigned on any path (no latch).
    pkt_data = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < int'(pkt_len)) pkt_data[8*i +: 8] = buf_q[i];
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_parser.sv
// Scoreboard bench for usb_rx_pkt_parser: the driver queues expected results,
// the monitor checks each result the parser raises.
`timescale 1ns/1ps
module tb_usb_rx_pkt_parser;
  import usb_rx_pkg::*;

  localparam int MAX_BYTES = 8;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);

  logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0, s_in = 1'b0, s_valid = 1'b0;
  logic sop = 1'b0, eop = 1'b0, pkt_ack = 1'b0;
  logic pkt_valid, pkt_is_data, err_valid, busy;
  logic [7:0] pkt_pid;
  logic [8*MAX_BYTES-1:0] pkt_data;
  logic [LEN_W-1:0] pkt_len;
  logic [1:0] err_code;

  usb_rx_pkt_parser #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .s_in(s_in), .s_valid(s_valid),
    .sop(sop), .eop(eop), .pkt_ack(pkt_ack), .pkt_valid(pkt_valid),
    .pkt_is_data(pkt_is_data), .pkt_pid(pkt_pid), .pkt_data(pkt_data),
    .pkt_len(pkt_len), .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic sop, sv, sin, eop, abt; } beat_t;
  typedef struct {
    logic is_err; logic [1:0] code; logic is_data; logic [7:0] pid;
    int len; logic [63:0] data; int exp_cyc;
  } exp_t;
  typedef logic [7:0] bytes_t[$];

  beat_t  beats[$];
  exp_t   exp_q[$];
  bytes_t none;
  int     term_idx = 0;
  bit     gaps = 0, merge_sop = 0;
  int     checks = 0, errors = 0, ev_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC16 (reflected byte-wise form); returns the two bytes to send, low byte first.
  function automatic logic [15:0] crc16_usb(input bytes_t d);
    logic [15:0] r;
    r = 16'hFFFF;
    foreach (d[i]) begin
      r = r ^ {8'h00, d[i]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r ^ 16'hFFFF;
  endfunction

  function automatic exp_t mk(input logic is_err, input logic [1:0] code, input logic is_data,
                              input logic [7:0] pid, input bytes_t pl);
    exp_t e;
    e.is_err = is_err; e.code = code; e.is_data = is_data; e.pid = pid;
    e.len = pl.size(); e.data = '0; e.exp_cyc = 0;
    foreach (pl[i]) e.data[8*i +: 8] = pl[i];
    return e;
  endfunction

  task automatic add_beat(input logic s, input logic v, input logic b, input logic e, input logic a);
    beat_t t;
    t.sop = s; t.sv = v; t.sin = b; t.eop = e; t.abt = a;
    beats.push_back(t);
  endtask

  task automatic add_bit(input logic b);
    beat_t t;
    if (merge_sop && beats.size() > 0 && beats[beats.size()-1].sop && !beats[beats.size()-1].sv) begin
      t = beats[beats.size()-1];
      t.sv = 1'b1; t.sin = b;
      beats[beats.size()-1] = t;
    end else begin
      if (gaps) repeat ($urandom_range(0, 2)) add_beat(0, 0, 0, 0, 0);
      add_beat(0, 1, b, 0, 0);
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) add_bit(b[i]);
  endtask

  task automatic add_eop();
    if (gaps) repeat ($urandom_range(0, 2)) add_beat(0, 0, 0, 0, 0);
    add_beat(0, 0, 0, 1, 0);
  endtask

  task automatic mark_term();
    term_idx = beats.size() - 1;
  endtask

  // DATA packet: pid, frame bytes, CRC of crc_src, optional trailing bits, eop.
  task automatic build_data(input logic [7:0] pid, input bytes_t frame, input bytes_t crc_src,
                            input int extra);
    logic [15:0] c;
    c = crc16_usb(crc_src);
    add_beat(1, 0, 0, 0, 0);
    add_byte(pid);
    foreach (frame[i]) add_byte(frame[i]);
    add_byte(c[7:0]);
    add_byte(c[15:8]);
    for (int i = 0; i < extra; i++) add_bit(1'b1);
    add_eop();
    mark_term();
  endtask

  task automatic run(input bit expect_result, input exp_t e);
    if (expect_result) begin
      e.exp_cyc = cyc + term_idx + 1;
      exp_q.push_back(e);
    end
    foreach (beats[i]) begin
      sop = beats[i].sop; s_valid = beats[i].sv; s_in = beats[i].sin;
      eop = beats[i].eop; abort = beats[i].abt;
      @(negedge clk);
    end
    sop = 0; s_valid = 0; s_in = 0; eop = 0; abort = 0;
    beats.delete();
  endtask

  task automatic send(input exp_t e, input bit inject_sop);
    int n0;
    n0 = ev_count;
    run(1'b1, e);
    for (int i = 0; i < 100 && ev_count == n0; i++) @(negedge clk);
    check("result_seen", ev_count > n0, 1);
    if (inject_sop) begin
      sop = 1; @(negedge clk); sop = 0;
      for (int i = 0; i < 8; i++) begin s_valid = 1; s_in = PID_NAK[i]; @(negedge clk); end
      s_valid = 0; eop = 1; @(negedge clk); eop = 0;
      check("pid_held_over_sop", pkt_pid, e.pid);
    end
    repeat (2) @(negedge clk);
    check("held_valid", {pkt_valid, err_valid}, {!e.is_err, e.is_err});
    check("busy_while_held", busy, 1);
    pkt_ack = 1; @(negedge clk); pkt_ack = 0;
    check("valid_after_ack", {pkt_valid, err_valid}, 0);
    check("busy_after_ack", busy, 0);
  endtask

  // Monitor: each new result is compared against the oldest queued expectation.
  logic prev_out = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if ((pkt_valid || err_valid) && !prev_out) begin
      ev_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", {pkt_valid, err_valid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency_cycle", cyc, e.exp_cyc);
        check("err_valid", err_valid, e.is_err);
        check("pkt_valid", pkt_valid, !e.is_err);
        check("err_code", err_code, e.is_err ? e.code : ERR_NONE);
        if (!e.is_err) begin
          check("pkt_is_data", pkt_is_data, e.is_data);
          check("pkt_pid", pkt_pid, e.pid);
          check("pkt_len", pkt_len, e.len);
          check("pkt_data", pkt_data, e.data);
        end
      end
    end
    prev_out = pkt_valid || err_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t pl, bad;
    exp_t   dummy;
    dummy = mk(0, ERR_NONE, 0, 8'h00, none);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_pid", pkt_pid, 0);
    check("rst_pkt_len", pkt_len, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_is_data", pkt_is_data, 0);
    rst_n = 1; @(negedge clk);

    // ACK, first bit on the sop cycle
    merge_sop = 1; gaps = 0;
    add_beat(1, 0, 0, 0, 0); add_byte(PID_ACK); add_eop(); mark_term();
    send(mk(0, ERR_NONE, 0, PID_ACK, none), 0);

    // DATA0 00 01 02 03
    pl.delete(); for (int i = 0; i < 4; i++) pl.push_back(8'(i));
    build_data(PID_DATA0, pl, pl, 0);
    send(mk(0, ERR_NONE, 1, PID_DATA0, pl), 0);

    // Same packet with random s_valid gaps
    merge_sop = 0; gaps = 1;
    build_data(PID_DATA0, pl, pl, 0);
    send(mk(0, ERR_NONE, 1, PID_DATA0, pl), 0);
    gaps = 0;

    // One payload bit flipped -> CRC error
    bad = pl; bad[2] = bad[2] ^ 8'h10;
    build_data(PID_DATA0, bad, pl, 0);
    send(mk(1, ERR_CRC, 0, 8'h00, none), 0);

    // PID C2 -> PID error right after the 8th bit; trailing eop ignored
    add_beat(1, 0, 0, 0, 0); add_byte(8'hC2); mark_term(); add_eop();
    send(mk(1, ERR_PID, 0, 8'h00, none), 0);

    // eop after 5 PID bits -> length error
    add_beat(1, 0, 0, 0, 0); for (int i = 0; i < 5; i++) add_bit(PID_ACK[i]); add_eop(); mark_term();
    send(mk(1, ERR_LEN, 0, 8'h00, none), 0);

    // NAK then 3 extra bits -> length error on the first extra bit
    add_beat(1, 0, 0, 0, 0); add_byte(PID_NAK); add_bit(1'b0); mark_term();
    add_bit(1'b1); add_bit(1'b0); add_eop();
    send(mk(1, ERR_LEN, 0, 8'h00, none), 0);

    // Zero-length DATA1
    build_data(PID_DATA1, none, none, 0);
    send(mk(0, ERR_NONE, 1, PID_DATA1, none), 0);

    // MAX_BYTES payload accepted
    pl.delete(); for (int i = 0; i < MAX_BYTES; i++) pl.push_back(8'(8'h11 * (i + 1)));
    build_data(PID_DATA1, pl, pl, 0);
    send(mk(0, ERR_NONE, 1, PID_DATA1, pl), 0);

    // MAX_BYTES+1 payload -> length error when the (MAX+3)th byte completes
    pl.push_back(8'hE7);
    add_beat(1, 0, 0, 0, 0); add_byte(PID_DATA0);
    foreach (pl[i]) add_byte(pl[i]);
    add_byte(crc16_usb(pl) & 16'h00FF);
    add_byte(crc16_usb(pl) >> 8); mark_term(); add_eop();
    send(mk(1, ERR_LEN, 0, 8'h00, none), 0);

    // Good CRC followed by 7 extra bits -> length error
    pl.delete(); for (int i = 0; i < 4; i++) pl.push_back(8'(8'hA0 + i));
    build_data(PID_DATA0, pl, pl, 7);
    send(mk(1, ERR_LEN, 0, 8'h00, none), 0);

    // abort mid-DATA: idle on the next cycle, later eop ignored
    add_beat(1, 0, 0, 0, 0); add_byte(PID_DATA0); add_byte(8'h55); add_byte(8'hAA);
    add_beat(0, 0, 0, 0, 1);
    run(0, dummy);
    check("abort_busy", busy, 0);
    check("abort_valid", {pkt_valid, err_valid}, 0);
    add_eop(); add_beat(0, 0, 0, 0, 0); add_beat(0, 0, 0, 0, 0);
    run(0, dummy);
    check("abort_eop_ignored", {busy, pkt_valid, err_valid}, 0);

    // Packet after abort, with a sop ignored while the result is held
    add_beat(1, 0, 0, 0, 0); add_byte(PID_ACK); add_eop(); mark_term();
    send(mk(0, ERR_NONE, 0, PID_ACK, none), 1);
    add_beat(1, 0, 0, 0, 0); add_byte(PID_NAK); add_eop(); mark_term();
    send(mk(0, ERR_NONE, 0, PID_NAK, none), 0);

    // Asynchronous reset mid-packet
    add_beat(1, 0, 0, 0, 0); add_byte(PID_DATA1); add_byte(8'h12);
    add_bit(1'b1); add_bit(1'b0); add_bit(1'b1);
    run(0, dummy);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_pid", pkt_pid, PID_DATA1);
    #2 rst_n = 0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_pid", pkt_pid, 0);
    check("async_rst_valid", {pkt_valid, err_valid, err_code}, 0);
    @(negedge clk); rst_n = 1; @(negedge clk);

    // Packet after reset
    pl.delete(); pl.push_back(8'hA5); pl.push_back(8'h5A); pl.push_back(8'hFF);
    merge_sop = 1;
    build_data(PID_DATA1, pl, pl, 0);
    send(mk(0, ERR_NONE, 1, PID_DATA1, pl), 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
